// File: rtl/hc595_frame_rx.sv
// Serial word receiver fed by a 74HC595-style cascade output, with frame
// resynchronisation, sticky error flags and a first-word-fall-through FIFO.
module hc595_frame_rx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       SRCLK,
  input  logic                       _SRCLR,
  input  logic                       SER_IN,
  input  logic                       EN,
  input  logic                       FRAME,
  input  logic                       CLRERR,
  output logic [WIDTH-1:0]           DOUT,
  output logic                       DVALID,
  input  logic                       DREADY,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                       OVF,
  output logic                       FERR
);

  localparam int CW   = $clog2(WIDTH);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);

  // Only WIDTH-1 bits are stored; the final bit is taken straight from SER_IN.
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             ferr_q, ferr_d;

  logic [WIDTH-1:0] newWord;
  logic             complete;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             doWrite;
  logic             ovfSet;
  logic             ferrSet;

  assign newWord  = {shreg_q, SER_IN};
  assign complete = EN && (bitcnt_q == CW'(WIDTH-1));
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNTW'(DEPTH));
  assign push     = complete;
  assign pop      = !empty && DREADY;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign doWrite  = push && (!full || pop);
  assign ovfSet   = push && full && !pop;
  assign ferrSet  = FRAME && !complete && (EN || (bitcnt_q != '0));

  always_comb begin
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    if (EN) begin
      shreg_d  = newWord[WIDTH-2:0];
      bitcnt_d = bitcnt_q + CW'(1);
    end
    if (complete || FRAME) begin
      shreg_d  = '0;
      bitcnt_d = '0;
    end
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doWrite) begin
      wrPtr_d = wrPtr_q + PW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end
    if (doWrite && !pop) begin
      count_d = count_q + CNTW'(1);
    end else if (!doWrite && pop) begin
      count_d = count_q - CNTW'(1);
    end
  end

  // Setting an error flag outranks clearing it on the same edge.
  always_comb begin
    ovf_d  = ovf_q;
    ferr_d = ferr_q;
    if (CLRERR) begin
      ovf_d  = 1'b0;
      ferr_d = 1'b0;
    end
    if (ovfSet) begin
      ovf_d = 1'b1;
    end
    if (ferrSet) begin
      ferr_d = 1'b1;
    end
  end

  always_ff @(posedge SRCLK or negedge _SRCLR) begin
    if (!_SRCLR) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      ferr_q   <= ferr_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge SRCLK) begin
    if (doWrite) begin
      mem_q[wrPtr_q] <= newWord;
    end
  end

  assign DVALID = !empty;
  assign DOUT   = empty ? '0 : mem_q[rdPtr_q];
  assign COUNT  = count_q;
  assign OVF    = ovf_q;
  assign FERR   = ferr_q;

endmodule
